// File: rtl/seq_mag_comparator_if.sv
// Handshake and operand bundle for the sequential magnitude comparator.
// The master issues start, operands and cascade inputs. The slave returns status and the registered result.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = $clog2(ND + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Igt;
  logic             Ilt;
  logic             Ieq;
  logic             signed_mode;
  logic             ready;
  logic             busy;
  logic             done;
  logic             Fgt;
  logic             Flt;
  logic             Feq;
  logic [CW-1:0]    cycles;

  modport master (
    output start, A, B, Igt, Ilt, Ieq, signed_mode,
    input  ready, busy, done, Fgt, Flt, Feq, cycles
  );

  modport slave (
    input  start, A, B, Igt, Ilt, Ieq, signed_mode,
    output ready, busy, done, Fgt, Flt, Feq, cycles
  );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator that examines one DIGIT-bit slice per clock, starting at the MSB slice.
// It stops at the first slice that differs. When every slice is equal, 74HC85-style cascade inputs decide the result.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_mag_comparator_if.slave  bus
);
  localparam int ND = WIDTH / DIGIT;
  localparam int CW = $clog2(ND + 1);
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;
  localparam int NS = 1 << IW;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             igt_q, ilt_q, ieq_q, sm_q;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             fgt_q, flt_q, feq_q;
  logic [CW-1:0]    cycles_q;
  logic [DIGIT-1:0] a_sl [NS];
  logic [DIGIT-1:0] b_sl [NS];
  logic [DIGIT-1:0] sa, sb;
  logic             accept, slice_ne, last_slice;
  logic             ready, busy, done;

  // Resolve an all-equal compare from the cascade inputs, returned as {gt, lt, eq}.
  function automatic logic [2:0] cascade(input logic gt, input logic lt, input logic eq);
    if (eq)             return 3'b001;
    else if (gt && !lt) return 3'b100;
    else if (!gt && lt) return 3'b010;
    else if (!gt && !lt) return 3'b110;
    else                return 3'b000;
  endfunction

  // Split the latched operands into slices. Table entries past ND are padded so that idx can address the table at its full width.
  for (genvar s = 0; s < NS; s++) begin : g_sl
    if (s < ND) begin : g_live
      assign a_sl[s] = a_q[s*DIGIT +: DIGIT];
      assign b_sl[s] = b_q[s*DIGIT +: DIGIT];
    end else begin : g_pad
      assign a_sl[s] = '0;
      assign b_sl[s] = '0;
    end
  end

  // Select the current slice. In signed mode, flip the sign bit of the top slice so that an unsigned compare orders it correctly.
  always_comb begin
    sa = a_sl[idx];
    sb = b_sl[idx];
    if (sm_q && (idx == IW'(ND - 1))) begin
      sa[DIGIT-1] = ~sa[DIGIT-1];
      sb[DIGIT-1] = ~sb[DIGIT-1];
    end
  end

  assign slice_ne   = (sa != sb);
  assign last_slice = (idx == '0);
  assign accept     = (state == IDLE) && bus.start;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: leave CMP on the first differing slice or after the last slice.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CMP;
      CMP:     if (slice_ne || last_slice) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      CMP:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Operand capture at acceptance. This is data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      igt_q <= bus.Igt;
      ilt_q <= bus.Ilt;
      ieq_q <= bus.Ieq;
      sm_q  <= bus.signed_mode;
    end
  end

  // Slice walk and result registers. Results change only when a comparison resolves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      cnt      <= '0;
      fgt_q    <= 1'b0;
      flt_q    <= 1'b0;
      feq_q    <= 1'b0;
      cycles_q <= '0;
    end else if (accept) begin
      idx <= IW'(ND - 1);
      cnt <= '0;
    end else if (state == CMP) begin
      if (slice_ne) begin
        fgt_q    <= (sa > sb);
        flt_q    <= (sa < sb);
        feq_q    <= 1'b0;
        cycles_q <= cnt + 1'b1;
      end else if (last_slice) begin
        {fgt_q, flt_q, feq_q} <= cascade(igt_q, ilt_q, ieq_q);
        cycles_q              <= CW'(ND);
      end else begin
        idx <= idx - 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.Fgt    = fgt_q;
  assign bus.Flt    = flt_q;
  assign bus.Feq    = feq_q;
  assign bus.cycles = cycles_q;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator. It drives a 16-bit/4-bit instance and a 4-bit/4-bit (single slice) instance.
module tb_seq_mag_comparator;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc_n = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_mag_comparator_if #(.WIDTH(16), .DIGIT(4)) bus16();
  seq_mag_comparator_if #(.WIDTH(4),  .DIGIT(4)) bus4();

  seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  seq_mag_comparator #(.WIDTH(4),  .DIGIT(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  typedef struct {
    logic fgt;
    logic flt;
    logic feq;
    int   cyc;
    int   due;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t last[2];
  int   busy_n[2];
  logic prev_done[2];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: a signed or unsigned integer compare, with the slice count taken from the highest differing digit.
  function automatic exp_t model(input int w, input int d, input logic [15:0] a, input logic [15:0] b,
                                 input logic igt, input logic ilt, input logic ieq, input logic sm);
    exp_t e;
    int nd, msk, va, vb;
    bit found;
    nd = w / d;
    msk = (1 << d) - 1;
    e.cyc = nd;
    e.due = 0;
    found = 0;
    for (int s = nd - 1; s >= 0; s--) begin
      if (!found && (((int'(a) >> (s*d)) & msk) != ((int'(b) >> (s*d)) & msk))) begin
        found = 1;
        e.cyc = nd - s;
      end
    end
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (sm && va[w-1]) va = va - (1 << w);
    if (sm && vb[w-1]) vb = vb - (1 << w);
    if (va == vb) begin
      e.fgt = 0; e.flt = 0; e.feq = 0;
      if (ieq)              e.feq = 1;
      else if (igt && !ilt) e.fgt = 1;
      else if (!igt && ilt) e.flt = 1;
      else if (!igt && !ilt) begin e.fgt = 1; e.flt = 1; end
    end else begin
      e.fgt = (va > vb);
      e.flt = (va < vb);
      e.feq = 0;
    end
    return e;
  endfunction

  task automatic mon(input int id, input logic dn, input logic rdy, input logic bsy,
                     input logic gt, input logic lt, input logic eq, input int cy);
    exp_t e;
    string p;
    int qs;
    p = (id == 0) ? "w16" : "w4";
    if (bsy) begin
      busy_n[id]++;
      check_eq({p, "_hold_gt"}, 32'(gt), 32'(last[id].fgt));
      check_eq({p, "_hold_lt"}, 32'(lt), 32'(last[id].flt));
      check_eq({p, "_hold_eq"}, 32'(eq), 32'(last[id].feq));
    end
    if (prev_done[id]) check_eq({p, "_ready_after_done"}, 32'(rdy), 32'd1);
    if (dn) begin
      check_eq({p, "_ready_in_done"}, 32'(rdy), 32'd0);
      check_eq({p, "_busy_in_done"}, 32'(bsy), 32'd0);
      qs = (id == 0) ? q16.size() : q4.size();
      check_eq({p, "_done_expected"}, 32'(qs > 0), 32'd1);
      if (qs > 0) begin
        e = (id == 0) ? q16.pop_front() : q4.pop_front();
        check_eq({p, "_Fgt"}, 32'(gt), 32'(e.fgt));
        check_eq({p, "_Flt"}, 32'(lt), 32'(e.flt));
        check_eq({p, "_Feq"}, 32'(eq), 32'(e.feq));
        check_eq({p, "_cycles"}, 32'(cy), 32'(e.cyc));
        check_eq({p, "_done_edge"}, 32'(cyc_n), 32'(e.due));
        check_eq({p, "_busy_len"}, 32'(busy_n[id]), 32'(e.cyc));
        last[id] = e;
      end
      busy_n[id] = 0;
    end
    prev_done[id] = dn;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        last[i] = '{fgt: 1'b0, flt: 1'b0, feq: 1'b0, cyc: 0, due: 0};
        busy_n[i] = 0;
        prev_done[i] = 1'b0;
      end
    end else begin
      mon(0, bus16.done, bus16.ready, bus16.busy, bus16.Fgt, bus16.Flt, bus16.Feq, int'(bus16.cycles));
      mon(1, bus4.done, bus4.ready, bus4.busy, bus4.Fgt, bus4.Flt, bus4.Feq, int'(bus4.cycles));
    end
  end

  // mode 0: plain; mode 1: extra start and an A change during CMP; mode 2: reset at the second CMP cycle.
  task automatic go(input int sel, input logic [15:0] a, input logic [15:0] b, input logic igt,
                    input logic ilt, input logic ieq, input logic sm, input int mode);
    exp_t e;
    int t;
    t = 0;
    while (!((sel == 0) ? bus16.ready : bus4.ready) && t < 64) begin @(negedge clk); t++; end
    check_eq("ready_wait", 32'(t < 64), 32'd1);
    e = model((sel == 0) ? 16 : 4, 4, a, b, igt, ilt, ieq, sm);
    e.due = cyc_n + 1 + e.cyc;
    if (sel == 0) begin
      bus16.A = a; bus16.B = b; bus16.Igt = igt; bus16.Ilt = ilt; bus16.Ieq = ieq;
      bus16.signed_mode = sm; bus16.start = 1'b1;
      if (mode != 2) q16.push_back(e);
    end else begin
      bus4.A = a[3:0]; bus4.B = b[3:0]; bus4.Igt = igt; bus4.Ilt = ilt; bus4.Ieq = ieq;
      bus4.signed_mode = sm; bus4.start = 1'b1;
      q4.push_back(e);
    end
    @(negedge clk);
    bus16.start = 1'b0;
    bus4.start = 1'b0;
    if (mode == 1) begin
      bus16.start = 1'b1;
      bus16.A = 16'hFFFF;
      @(negedge clk);
      bus16.start = 1'b0;
    end
    if (mode == 2) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("abort_Fgt", 32'(bus16.Fgt), 32'd0);
      check_eq("abort_Flt", 32'(bus16.Flt), 32'd0);
      check_eq("abort_Feq", 32'(bus16.Feq), 32'd0);
      check_eq("abort_done", 32'(bus16.done), 32'd0);
      check_eq("abort_ready", 32'(bus16.ready), 32'd1);
      check_eq("abort_cycles", 32'(bus16.cycles), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      return;
    end
    t = 0;
    while (((sel == 0) ? q16.size() : q4.size()) != 0 && t < 64) begin @(negedge clk); t++; end
    check_eq("done_wait", 32'(t < 64), 32'd1);
    q16.delete();
    q4.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int sl;
    rst_n = 1'b0;
    bus16.start = 0; bus16.A = 0; bus16.B = 0; bus16.Igt = 0; bus16.Ilt = 0; bus16.Ieq = 0; bus16.signed_mode = 0;
    bus4.start = 0;  bus4.A = 0;  bus4.B = 0;  bus4.Igt = 0;  bus4.Ilt = 0;  bus4.Ieq = 0;  bus4.signed_mode = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(bus16.ready), 32'd1);
    check_eq("rst_busy", 32'(bus16.busy), 32'd0);
    check_eq("rst_done", 32'(bus16.done), 32'd0);
    check_eq("rst_flags", 32'({bus16.Fgt, bus16.Flt, bus16.Feq}), 32'd0);
    check_eq("rst_cycles", 32'(bus16.cycles), 32'd0);
    check_eq("rst_w4_flags", 32'({bus4.Fgt, bus4.Flt, bus4.Feq, bus4.cycles}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    go(0, 16'h1234, 16'h0234, 0, 0, 1, 0, 0);
    go(0, 16'h1234, 16'h1235, 0, 0, 1, 0, 0);
    go(0, 16'hABCD, 16'hABCD, 0, 0, 1, 0, 0);
    go(0, 16'hABCD, 16'hABCD, 1, 0, 0, 0, 0);
    go(0, 16'hABCD, 16'hABCD, 0, 0, 0, 0, 0);
    go(0, 16'hABCD, 16'hABCD, 1, 1, 0, 0, 0);
    go(0, 16'h8000, 16'h0001, 0, 0, 0, 1, 0);
    go(0, 16'h8000, 16'h0001, 0, 0, 0, 0, 0);
    go(0, 16'hFFFF, 16'hFFFE, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      sl = $urandom_range(0, 3);
      rb = ra ^ 16'(32'($urandom_range(1, 15)) << (4 * sl));
      go(0, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    end
    go(0, 16'h0001, 16'h0002, 0, 0, 0, 0, 1);
    go(0, 16'h0001, 16'h0002, 0, 0, 0, 0, 2);

    go(1, 16'h0, 16'hF, 1, 0, 0, 0, 0);
    go(1, 16'h7, 16'h3, 0, 1, 0, 0, 0);
    go(1, 16'h0, 16'h0, 0, 0, 1, 0, 0);
    go(1, 16'h5, 16'h2, 0, 0, 0, 0, 0);
    go(1, 16'h8, 16'h6, 0, 0, 0, 0, 0);
    go(1, 16'h8, 16'h6, 0, 0, 0, 1, 0);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
